// File: rtl/hockey_player_input.sv
// Per-player button front-end: synchronize, debounce, one-cycle press pulse, release lockout.
// Direction and row are latched and sanitized on the same edge that a press is accepted.
module hockey_player_input #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned LOCKOUT_CYCLES  = 2,
   parameter int unsigned Y_MAX           = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_raw,
   input  logic [1:0] dir_sw,
   input  logic [2:0] y_sw,
   output logic       btn_out,
   output logic [1:0] dir_out,
   output logic [2:0] y_out,
   output logic       busy
);

   localparam int unsigned CntMax = (DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ? DEBOUNCE_CYCLES
                                                                       : LOCKOUT_CYCLES;
   localparam int unsigned CntW = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] LockLast = CntW'(LOCKOUT_CYCLES);
   localparam logic [CntW-1:0] CntOne   = CntW'(1);
   localparam logic [2:0]      YMax     = 3'(Y_MAX);

   typedef enum logic [2:0] {
      StIdle,
      StDebounce,
      StPulse,
      StHold,
      StLockout
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sync1_q, btn_s_q;
   logic [1:0]      dir_q, dir_d;
   logic [2:0]      y_q, y_d;
   logic            accept;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (btn_s_q) begin
               // A single required sample means the first high one is already accepted.
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = StPulse;
                  accept  = 1'b1;
               end else begin
                  state_d = StDebounce;
                  cnt_d   = CntOne;
               end
            end
         end
         StDebounce: begin
            if (!btn_s_q) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == DebLast) begin
               state_d = StPulse;
               cnt_d   = '0;
               accept  = 1'b1;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StPulse: state_d = StHold;
         StHold: begin
            if (!btn_s_q) begin
               if (LOCKOUT_CYCLES == 0) begin
                  state_d = StIdle;
               end else begin
                  state_d = StLockout;
                  cnt_d   = CntOne;
               end
            end
         end
         StLockout: begin
            if (cnt_q == LockLast) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      dir_d = dir_q;
      y_d   = y_q;
      if (accept) begin
         dir_d = (dir_sw == 2'd3) ? 2'd0 : dir_sw;
         y_d   = (y_sw > YMax) ? YMax : y_sw;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sync1_q <= 1'b0;
         btn_s_q <= 1'b0;
         dir_q   <= 2'd0;
         y_q     <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sync1_q <= btn_raw;
         btn_s_q <= sync1_q;
         dir_q   <= dir_d;
         y_q     <= y_d;
      end
   end

   assign btn_out = (state_q == StPulse);
   assign busy    = (state_q != StIdle);
   assign dir_out = dir_q;
   assign y_out   = y_q;

endmodule
